// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage MIPS pipeline.
// Resolves, in priority order: data-memory wait (freeze), taken branch
// (flush), load-use / MDU-busy hazards (bubble), else free-running.
// Also tracks MDU occupancy and counts stalled cycles (saturating).
module pipe_hazard_ctrl #(
    parameter int RW      = 5,
    parameter int MDU_LAT = 32,
    parameter int CW      = 6,
    parameter int SW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_uses_rt,
    input  logic          id_mdu_use,
    input  logic          ex_memread,
    input  logic [RW-1:0] ex_rt,
    input  logic          ex_mdu_start,
    input  logic          ex_branch_taken,
    input  logic          mem_req,
    input  logic          mem_ready,
    output logic          pc_en,
    output logic          ifid_en,
    output logic          ifid_flush,
    output logic          idex_en,
    output logic          idex_flush,
    output logic          exmem_en,
    output logic          memwb_en,
    output logic          mem_wait,
    output logic          mdu_busy,
    output logic [SW-1:0] stall_cycles
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] mdu_cnt_q, mdu_cnt_d;
    logic [SW-1:0] stall_q, stall_d;

    logic freeze;
    logic lu;
    logic mh;

    // Hazard conditions; register $zero is never a real dependency
    always_comb begin
        freeze = mem_req & ~mem_ready;
        lu     = ex_memread & (ex_rt != '0) &
                 ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
        mh     = id_mdu_use & mdu_busy;
    end

    // Next-state and per-stage controls; everything is held low while in reset
    always_comb begin
        state_d    = state_q;
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_en    = 1'b0;
        idex_flush = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        if (rst_n) begin
            if (freeze) begin
                // Whole pipe holds; a pending branch stays in EX and is seen later
            end else if (ex_branch_taken) begin
                // ID instruction is squashed, so its hazards do not matter
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
                idex_en    = 1'b1;
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end else if (lu | mh) begin
                // Hold IF/ID and PC, push one bubble into EX per stalled cycle
                idex_en    = 1'b1;
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end

            case (state_q)
                ST_RUN:  if (freeze)    state_d = ST_WAIT;
                ST_WAIT: if (mem_ready) state_d = ST_RUN;
                default: state_d = ST_RUN;
            endcase
        end
    end

    // MDU countdown: a start that is frozen in EX loads on the first unfrozen edge
    always_comb begin
        if (ex_mdu_start && !freeze) begin
            mdu_cnt_d = CW'(MDU_LAT);
        end else if (mdu_cnt_q != '0) begin
            mdu_cnt_d = mdu_cnt_q - CW'(1);
        end else begin
            mdu_cnt_d = mdu_cnt_q;
        end
    end

    // Saturating count of cycles in which the PC did not advance
    always_comb begin
        if (!pc_en && (stall_q != '1)) begin
            stall_d = stall_q + SW'(1);
        end else begin
            stall_d = stall_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            mdu_cnt_q <= '0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            mdu_cnt_q <= mdu_cnt_d;
            stall_q   <= stall_d;
        end
    end

    assign mem_wait     = (state_q == ST_WAIT);
    assign mdu_busy     = (mdu_cnt_q != '0);
    assign stall_cycles = stall_q;

endmodule
